// File: rtl/vx_socket_mem_throttle.sv
// Socket L1-to-L2 request throttle: 2-entry request FIFO,
// read credit cap, registered response stage, stall stats.
module vx_socket_mem_throttle #(
  parameter int DATA_SIZE   = 64,
  parameter int ADDR_WIDTH  = 26,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      in_req_valid,
  input  logic                      in_req_rw,
  input  logic [ADDR_WIDTH-1:0]     in_req_addr,
  input  logic [8*DATA_SIZE-1:0]    in_req_data,
  input  logic [DATA_SIZE-1:0]      in_req_byteen,
  input  logic [TAG_WIDTH-1:0]      in_req_tag,
  output logic                      in_req_ready,

  output logic                      out_req_valid,
  output logic                      out_req_rw,
  output logic [ADDR_WIDTH-1:0]     out_req_addr,
  output logic [8*DATA_SIZE-1:0]    out_req_data,
  output logic [DATA_SIZE-1:0]      out_req_byteen,
  output logic [TAG_WIDTH-1:0]      out_req_tag,
  input  logic                      out_req_ready,

  input  logic                      out_rsp_valid,
  input  logic [8*DATA_SIZE-1:0]    out_rsp_data,
  input  logic [TAG_WIDTH-1:0]      out_rsp_tag,
  output logic                      out_rsp_ready,

  output logic                      in_rsp_valid,
  output logic [8*DATA_SIZE-1:0]    in_rsp_data,
  output logic [TAG_WIDTH-1:0]      in_rsp_tag,
  input  logic                      in_rsp_ready,

  output logic [$clog2(MAX_PENDING+1)-1:0] pending,
  output logic [31:0]               stall_cycles,
  output logic                      busy
);

  localparam int DW = 8 * DATA_SIZE;
  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_PENDING);

  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DW-1:0]         data;
    logic [DATA_SIZE-1:0]  byteen;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  req_t           in_pkt;
  req_t           slot0;
  req_t           slot1;
  logic [1:0]     cnt;
  logic [1:0]     cnt_nxt;
  logic           push;
  logic           pop;
  logic           rd_acc;
  logic           rsp_hs;
  logic [CW-1:0]  pend_r;
  logic [CW-1:0]  pend_nxt;
  logic           rsp_vld_r;
  logic [DW-1:0]  rsp_data_r;
  logic [TAG_WIDTH-1:0] rsp_tag_r;
  logic [31:0]    stall_r;

  assign in_pkt = '{
    rw:     in_req_rw,
    addr:   in_req_addr,
    data:   in_req_data,
    byteen: in_req_byteen,
    tag:    in_req_tag
  };

  // Writes never produce a response, so only reads need credit.
  assign in_req_ready = reset
                     && (cnt != 2'd2)
                     && (in_req_rw || (pend_r < CAP));

  assign push   = in_req_valid && in_req_ready;
  assign pop    = out_req_valid && out_req_ready;
  assign rd_acc = push && !in_req_rw;
  assign rsp_hs = out_rsp_valid && out_rsp_ready;

  assign out_req_valid  = (cnt != 2'd0);
  assign out_req_rw     = slot0.rw;
  assign out_req_addr   = slot0.addr;
  assign out_req_data   = slot0.data;
  assign out_req_byteen = slot0.byteen;
  assign out_req_tag    = slot0.tag;

  always_comb begin
    cnt_nxt = cnt;
    unique case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // Payload slots carry no reset; validity lives in cnt.
  always_ff @(posedge clk) begin
    if (push && pop) begin
      slot0 <= in_pkt;
    end else if (pop) begin
      slot0 <= slot1;
    end else if (push) begin
      if (cnt == 2'd0) begin
        slot0 <= in_pkt;
      end else begin
        slot1 <= in_pkt;
      end
    end
  end

  always_comb begin
    pend_nxt = pend_r;
    if (rd_acc && !rsp_hs) begin
      pend_nxt = pend_r + CW'(1);
    end else if (!rd_acc && rsp_hs && (pend_r != '0)) begin
      pend_nxt = pend_r - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r <= '0;
    end else begin
      pend_r <= pend_nxt;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (!(rsp_hs && !rd_acc && (pend_r == '0)))
        else $error("response with no outstanding read");
    end
  end
`endif

  assign out_rsp_ready = reset && (!rsp_vld_r || in_rsp_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld_r <= 1'b0;
    end else if (rsp_hs) begin
      rsp_vld_r <= 1'b1;
    end else if (in_rsp_ready) begin
      rsp_vld_r <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_hs) begin
      rsp_data_r <= out_rsp_data;
      rsp_tag_r  <= out_rsp_tag;
    end
  end

  assign in_rsp_valid = rsp_vld_r;
  assign in_rsp_data  = rsp_data_r;
  assign in_rsp_tag   = rsp_tag_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_r <= 32'd0;
    end else if (in_req_valid && !in_req_ready) begin
      stall_r <= stall_r + 32'd1;
    end
  end

  assign pending      = pend_r;
  assign stall_cycles = stall_r;
  assign busy         = (cnt != 2'd0) || (pend_r != '0) || rsp_vld_r;

endmodule

// File: tb/tb_vx_socket_mem_throttle.sv
// Directed bench for vx_socket_mem_throttle:
// vector table for the credit cap plus hand-written sequences.
module tb_vx_socket_mem_throttle;

  localparam int DS = 4;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int MP = 4;
  localparam int CW = $clog2(MP + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            in_req_valid;
  logic            in_req_rw;
  logic [AW-1:0]   in_req_addr;
  logic [8*DS-1:0] in_req_data;
  logic [DS-1:0]   in_req_byteen;
  logic [TW-1:0]   in_req_tag;
  logic            in_req_ready;
  logic            out_req_valid;
  logic            out_req_rw;
  logic [AW-1:0]   out_req_addr;
  logic [8*DS-1:0] out_req_data;
  logic [DS-1:0]   out_req_byteen;
  logic [TW-1:0]   out_req_tag;
  logic            out_req_ready;
  logic            out_rsp_valid;
  logic [8*DS-1:0] out_rsp_data;
  logic [TW-1:0]   out_rsp_tag;
  logic            out_rsp_ready;
  logic            in_rsp_valid;
  logic [8*DS-1:0] in_rsp_data;
  logic [TW-1:0]   in_rsp_tag;
  logic            in_rsp_ready;
  logic [CW-1:0]   pending;
  logic [31:0]     stall_cycles;
  logic            busy;

  always #5 clk = ~clk;

  vx_socket_mem_throttle #(
    .DATA_SIZE   (DS),
    .ADDR_WIDTH  (AW),
    .TAG_WIDTH   (TW),
    .MAX_PENDING (MP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_req_valid   (in_req_valid),
    .in_req_rw      (in_req_rw),
    .in_req_addr    (in_req_addr),
    .in_req_data    (in_req_data),
    .in_req_byteen  (in_req_byteen),
    .in_req_tag     (in_req_tag),
    .in_req_ready   (in_req_ready),
    .out_req_valid  (out_req_valid),
    .out_req_rw     (out_req_rw),
    .out_req_addr   (out_req_addr),
    .out_req_data   (out_req_data),
    .out_req_byteen (out_req_byteen),
    .out_req_tag    (out_req_tag),
    .out_req_ready  (out_req_ready),
    .out_rsp_valid  (out_rsp_valid),
    .out_rsp_data   (out_rsp_data),
    .out_rsp_tag    (out_rsp_tag),
    .out_rsp_ready  (out_rsp_ready),
    .in_rsp_valid   (in_rsp_valid),
    .in_rsp_data    (in_rsp_data),
    .in_rsp_tag     (in_rsp_tag),
    .in_rsp_ready   (in_rsp_ready),
    .pending        (pending),
    .stall_cycles   (stall_cycles),
    .busy           (busy)
  );

  typedef struct {
    logic       v;
    logic       rw;
    logic [7:0] tag;
    logic       ordy;
    logic       rv;
    logic [7:0] rtag;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_ot;
    logic       e_orw;
    int         e_pd;
    logic       e_iv;
    logic [7:0] e_it;
    int         e_st;
    logic       e_bz;
  } vec_t;

  int pass_cnt = 0;
  int total    = 0;

  function automatic logic [31:0] dat(input logic [7:0] t);
    return {t, ~t, t ^ 8'h3C, 8'h5A};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic rw, input logic [7:0] t,
                     input logic ordy, input logic rv,
                     input logic [7:0] rt, input logic irdy);
    in_req_valid  = v;
    in_req_rw     = rw;
    in_req_tag    = t;
    in_req_addr   = {18'h0, t};
    in_req_data   = dat(t);
    in_req_byteen = t[3:0];
    out_req_ready = ordy;
    out_rsp_valid = rv;
    out_rsp_tag   = rt;
    out_rsp_data  = dat(rt);
    in_rsp_ready  = irdy;
  endtask

  vec_t tbl[12];

  initial begin
    int acc;
    int nxt;
    int exp_t;
    int got;
    logic [7:0] wt;

    tbl[0]  = '{1,0,8'h00,1,0,8'h00, 1,0,8'h00,0,0,0,8'h00,0,0};
    tbl[1]  = '{1,0,8'h01,1,0,8'h00, 1,1,8'h00,0,1,0,8'h00,0,1};
    tbl[2]  = '{1,0,8'h02,1,0,8'h00, 1,1,8'h01,0,2,0,8'h00,0,1};
    tbl[3]  = '{1,0,8'h03,1,0,8'h00, 1,1,8'h02,0,3,0,8'h00,0,1};
    tbl[4]  = '{1,0,8'h04,1,0,8'h00, 0,1,8'h03,0,4,0,8'h00,0,1};
    tbl[5]  = '{1,0,8'h04,1,0,8'h00, 0,0,8'h00,0,4,0,8'h00,1,1};
    tbl[6]  = '{1,0,8'h04,1,1,8'h00, 0,0,8'h00,0,4,0,8'h00,2,1};
    tbl[7]  = '{1,0,8'h04,1,0,8'h00, 1,0,8'h00,0,3,1,8'h00,3,1};
    tbl[8]  = '{1,0,8'h05,1,0,8'h00, 0,1,8'h04,0,4,0,8'h00,3,1};
    tbl[9]  = '{1,1,8'h80,1,0,8'h00, 1,0,8'h00,0,4,0,8'h00,4,1};
    tbl[10] = '{0,0,8'h00,1,0,8'h00, 0,1,8'h80,1,4,0,8'h00,4,1};
    tbl[11] = '{0,0,8'h00,1,0,8'h00, 0,0,8'h00,0,4,0,8'h00,4,1};

    reset = 1'b0;
    drv(0, 0, 8'h00, 1, 0, 8'h00, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst.in_req_ready", 64'(in_req_ready), 64'(0));
    chk("rst.out_rsp_ready", 64'(out_rsp_ready), 64'(0));

    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("idle.out_req_valid", 64'(out_req_valid), 64'(0));
    chk("idle.in_rsp_valid", 64'(in_rsp_valid), 64'(0));
    chk("idle.pending", 64'(pending), 64'(0));
    chk("idle.busy", 64'(busy), 64'(0));
    chk("idle.stall", 64'(stall_cycles), 64'(0));
    chk("idle.in_req_ready", 64'(in_req_ready), 64'(1));

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drv(tbl[i].v, tbl[i].rw, tbl[i].tag, tbl[i].ordy,
          tbl[i].rv, tbl[i].rtag, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d.in_req_ready", i),
          64'(in_req_ready), 64'(tbl[i].e_ir));
      chk($sformatf("v%0d.out_req_valid", i),
          64'(out_req_valid), 64'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d.out_req_tag", i),
            64'(out_req_tag), 64'(tbl[i].e_ot));
        chk($sformatf("v%0d.out_req_rw", i),
            64'(out_req_rw), 64'(tbl[i].e_orw));
      end
      chk($sformatf("v%0d.pending", i),
          64'(pending), 64'(tbl[i].e_pd));
      chk($sformatf("v%0d.in_rsp_valid", i),
          64'(in_rsp_valid), 64'(tbl[i].e_iv));
      if (tbl[i].e_iv) begin
        chk($sformatf("v%0d.in_rsp_tag", i),
            64'(in_rsp_tag), 64'(tbl[i].e_it));
      end
      chk($sformatf("v%0d.stall", i),
          64'(stall_cycles), 64'(tbl[i].e_st));
      chk($sformatf("v%0d.busy", i), 64'(busy), 64'(tbl[i].e_bz));
    end

    // back-to-back responses for tags 1..4, one per cycle
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      drv(0, 0, 8'h00, 1, k < 4, 8'(k + 1), 1);
      @(negedge clk);
      chk($sformatf("rsp%0d.pending", k), 64'(pending), 64'(4 - k));
      if (k > 0) begin
        chk($sformatf("rsp%0d.valid", k), 64'(in_rsp_valid), 64'(1));
        chk($sformatf("rsp%0d.tag", k), 64'(in_rsp_tag), 64'(k));
        chk($sformatf("rsp%0d.data", k), 64'(in_rsp_data), 64'(dat(8'(k))));
      end
    end
    @(posedge clk); #1;
    drv(0, 0, 8'h00, 1, 0, 8'h00, 1);
    @(negedge clk);
    chk("rsp.drained", 64'(in_rsp_valid), 64'(0));
    chk("rsp.busy", 64'(busy), 64'(0));

    for (int t = 5; t <= 8; t++) begin
      @(posedge clk); #1;
      drv(1, 0, 8'(t), 1, 0, 8'h00, 1);
      @(negedge clk);
      chk($sformatf("rd%0d.ready", t), 64'(in_req_ready), 64'(1));
    end
    @(posedge clk); #1;
    drv(0, 0, 8'h00, 1, 0, 8'h00, 1);
    @(negedge clk);
    chk("rd8.out_tag", 64'(out_req_tag), 64'(8'h08));

    // responses while the upstream side toggles its ready
    nxt = 5;
    exp_t = 5;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(posedge clk); #1;
      drv(0, 0, 8'h00, 1, nxt <= 8, 8'(nxt), (c % 2) == 0);
      @(negedge clk);
      if (in_rsp_valid && in_rsp_ready) begin
        chk($sformatf("tog.tag%0d", exp_t), 64'(in_rsp_tag), 64'(exp_t));
        chk($sformatf("tog.data%0d", exp_t),
            64'(in_rsp_data), 64'(dat(8'(exp_t))));
        exp_t++;
        got++;
      end
      if (out_rsp_valid && out_rsp_ready) nxt++;
    end
    chk("tog.count", 64'(got), 64'(4));
    @(posedge clk); #1;
    drv(0, 0, 8'h00, 1, 0, 8'h00, 1);
    @(negedge clk);
    chk("tog.pending", 64'(pending), 64'(0));
    chk("tog.in_rsp_valid", 64'(in_rsp_valid), 64'(0));

    // downstream stalled: a write stream fills exactly two slots
    acc = 0;
    wt = 8'h10;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drv(1, 1, wt, 0, 0, 8'h00, 1);
      @(negedge clk);
      if (c == 3) chk("bp.ready_low", 64'(in_req_ready), 64'(0));
      if (in_req_ready) begin
        acc++;
        wt++;
      end
    end
    chk("bp.accepted", 64'(acc), 64'(2));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drv(0, 0, 8'h00, 1, 0, 8'h00, 1);
      @(negedge clk);
      if (c < 2) begin
        chk($sformatf("bp.valid%0d", c), 64'(out_req_valid), 64'(1));
        chk($sformatf("bp.tag%0d", c), 64'(out_req_tag), 64'(8'h10 + c));
        chk($sformatf("bp.data%0d", c),
            64'(out_req_data), 64'(dat(8'(8'h10 + c))));
        chk($sformatf("bp.rw%0d", c), 64'(out_req_rw), 64'(1));
      end else begin
        chk("bp.empty", 64'(out_req_valid), 64'(0));
      end
    end

    // read accept and response handshake in the same cycle
    @(posedge clk); #1;
    drv(1, 0, 8'h20, 1, 0, 8'h00, 1);
    @(negedge clk);
    chk("sim.ready0", 64'(in_req_ready), 64'(1));
    chk("sim.pend0", 64'(pending), 64'(0));
    @(posedge clk); #1;
    drv(1, 0, 8'h21, 1, 1, 8'h20, 1);
    @(negedge clk);
    chk("sim.pend1", 64'(pending), 64'(1));
    chk("sim.ready1", 64'(in_req_ready), 64'(1));
    chk("sim.rsp_ready", 64'(out_rsp_ready), 64'(1));
    @(posedge clk); #1;
    drv(0, 0, 8'h00, 1, 0, 8'h00, 1);
    @(negedge clk);
    chk("sim.pend_hold", 64'(pending), 64'(1));
    chk("sim.rsp_tag", 64'(in_rsp_tag), 64'(8'h20));

    // asynchronous reset in the middle of a burst
    @(posedge clk); #1;
    drv(1, 0, 8'h30, 0, 0, 8'h00, 1);
    @(posedge clk); #1;
    drv(1, 0, 8'h31, 0, 0, 8'h00, 1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("ar.pending", 64'(pending), 64'(0));
    chk("ar.out_req_valid", 64'(out_req_valid), 64'(0));
    chk("ar.in_rsp_valid", 64'(in_rsp_valid), 64'(0));
    chk("ar.busy", 64'(busy), 64'(0));
    chk("ar.stall", 64'(stall_cycles), 64'(0));
    chk("ar.in_req_ready", 64'(in_req_ready), 64'(0));
    chk("ar.out_rsp_ready", 64'(out_rsp_ready), 64'(0));
    @(posedge clk); #1;
    chk("ar.hold_pending", 64'(pending), 64'(0));
    chk("ar.hold_valid", 64'(out_req_valid), 64'(0));
    reset = 1'b1;
    drv(0, 0, 8'h00, 1, 0, 8'h00, 1);
    @(negedge clk);
    chk("ar.release_ready", 64'(in_req_ready), 64'(1));
    chk("ar.release_busy", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
